// File: rtl/flag_unit.sv
// flag_unit: architectural NVZ flag register with in-flight flag-writer tracking
// and a decode stall for conditional branches that read F before it is final.
// Optional feature: define FLAG_FWD_EN to forward a same-cycle flag write to a
// waiting branch when it is the last writer in flight.
module flag_unit #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue,
   input  logic             br_need,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [2:0]       wr_mask,
   input  logic [15:0]      result,
   input  logic             ovfl,
   output logic [2:0]       F,
   output logic             stall,
   output logic [CNT_W-1:0] inflight,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       f_q;
   logic [2:0]       new_f;
   logic [2:0]       wr_f;
   logic [2:0]       f_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;
   logic             err_d;
   logic             issue_acc;

   // Candidate flags from the writing instruction, merged with held flags by mask
   always_comb begin
      new_f = {result[15], ovfl, (result == 16'h0000)};
      wr_f  = (new_f & wr_mask) | (f_q & ~wr_mask);
      f_d   = wr_en ? wr_f : f_q;
   end

`ifdef FLAG_FWD_EN
   logic fwd_hit;

   // Last in-flight writer retiring now: hand its flags straight to the branch
   always_comb begin
      fwd_hit = br_need & wr_en & (cnt_q == CNT_ONE);
      stall   = br_need & (cnt_q != CNT_ZERO) & ~fwd_hit;
      F       = fwd_hit ? wr_f : f_q;
   end
`else
   // Branch waits until every in-flight writer has updated the register
   always_comb begin
      stall = br_need & (cnt_q != CNT_ZERO);
      F     = f_q;
   end
`endif

   // In-flight counter next state; saturates at both ends and flags the error
   always_comb begin
      cnt_d     = cnt_q;
      err_d     = err_q;
      issue_acc = issue & ~stall;
      if (flush) begin
         cnt_d = CNT_ZERO;
      end else if (issue_acc && !wr_en) begin
         if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (wr_en && !issue_acc) begin
         if (cnt_q == CNT_ZERO) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f_q   <= 3'b000;
         cnt_q <= CNT_ZERO;
         err_q <= 1'b0;
      end else begin
         f_q   <= f_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign inflight = cnt_q;
   assign err      = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: each step drives inputs, checks the same-cycle
// stall/F, queues the expected post-edge state and compares it after the edge.
module tb_flag_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue;
   logic        br_need;
   logic        flush;
   logic        wr_en;
   logic [2:0]  wr_mask;
   logic [15:0] result;
   logic        ovfl;
   logic [2:0]  F;
   logic        stall;
   logic [1:0]  inflight;
   logic        err;

   typedef struct {
      string      tag;
      logic [2:0] f;
      logic [1:0] inf;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

`ifdef FLAG_FWD_EN
   localparam logic FWD_STALL = 1'b0;
   localparam logic [2:0] FWD_F_NOW = 3'b001;
`else
   localparam logic FWD_STALL = 1'b1;
   localparam logic [2:0] FWD_F_NOW = 3'b101;
`endif

   flag_unit #(.DEPTH(3), .CNT_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (issue),
      .br_need  (br_need),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_mask  (wr_mask),
      .result   (result),
      .ovfl     (ovfl),
      .F        (F),
      .stall    (stall),
      .inflight (inflight),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag, input logic rn, input logic iss,
                       input logic brn, input logic fl, input logic we,
                       input logic [2:0] m, input logic [15:0] res, input logic ov,
                       input logic exp_stall, input logic [2:0] exp_f_now,
                       input logic [2:0] ef, input logic [1:0] ei, input logic ee);
      exp_t e;
      rst_n = rn; issue = iss; br_need = brn; flush = fl;
      wr_en = we; wr_mask = m; result = res; ovfl = ov;
      #1;
      checks++;
      assert (stall === exp_stall) else begin
         errors++;
         $error("FAIL %s.stall got=%b exp=%b", tag, stall, exp_stall);
      end
      checks++;
      assert (F === exp_f_now) else begin
         errors++;
         $error("FAIL %s.F_now got=%b exp=%b", tag, F, exp_f_now);
      end
      e.tag = tag; e.f = ef; e.inf = ei; e.err = ee;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s.queue got=empty exp=entry", tag);
      end else begin
         e = exp_q.pop_front();
         checks++;
         assert (F === e.f) else begin
            errors++;
            $error("FAIL %s.F got=%b exp=%b", e.tag, F, e.f);
         end
         checks++;
         assert (inflight === e.inf) else begin
            errors++;
            $error("FAIL %s.inflight got=%0d exp=%0d", e.tag, inflight, e.inf);
         end
         checks++;
         assert (err === e.err) else begin
            errors++;
            $error("FAIL %s.err got=%b exp=%b", e.tag, err, e.err);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with active issue/wr_en
      step("rst0", 0, 1, 0, 0, 1, 3'b111, 16'h0000, 0,  0, dut.f_q, 3'b000, 2'd0, 0);
      step("rst1", 0, 1, 0, 0, 1, 3'b111, 16'h0000, 0,  0, 3'b000, 3'b000, 2'd0, 0);
      // Masked writes
      step("iss_a", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b000, 3'b000, 2'd1, 0);
      step("mw_101", 1, 0, 0, 0, 1, 3'b101, 16'h8000, 1, 0, 3'b000, 3'b100, 2'd0, 0);
      step("iss_b", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd1, 0);
      step("mw_001", 1, 0, 0, 0, 1, 3'b001, 16'h0000, 0, 0, 3'b100, 3'b101, 2'd0, 0);
      // Stall, ignored issue, write-through-stall / forwarding
      step("iss_c", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b101, 3'b101, 2'd1, 0);
      step("stall", 1, 1, 1, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b101, 3'b101, 2'd1, 0);
      step("st_wr", 1, 0, 1, 0, 1, 3'b111, 16'h0000, 0, FWD_STALL, FWD_F_NOW, 3'b001, 2'd0, 0);
      step("st_rel", 1, 0, 1, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b001, 3'b001, 2'd0, 0);
      // Flush with simultaneous write and issue
      step("iss_d", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b001, 3'b001, 2'd1, 0);
      step("iss_e", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b001, 3'b001, 2'd2, 0);
      step("flush", 1, 1, 0, 1, 1, 3'b111, 16'h8000, 1, 0, 3'b001, 3'b110, 2'd0, 0);
      // Simultaneous issue and write keeps the count
      step("iss_f", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b110, 3'b110, 2'd1, 0);
      step("iss_wr", 1, 1, 0, 0, 1, 3'b010, 16'h0000, 0, 0, 3'b110, 3'b100, 2'd1, 0);
      // Overflow at DEPTH
      step("iss_g", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd2, 0);
      step("iss_h", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd3, 0);
      step("ovf", 1, 1, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd3, 1);
      step("sticky", 1, 0, 0, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd3, 1);
      // Reset mid-operation, then underflow
      step("rst2", 0, 1, 1, 0, 1, 3'b111, 16'h8000, 1, 1, 3'b100, 3'b000, 2'd0, 0);
      step("unf", 1, 0, 0, 0, 1, 3'b111, 16'h8001, 0, 0, 3'b000, 3'b100, 2'd0, 1);
      step("idle", 1, 0, 1, 0, 0, 3'b000, 16'h0000, 0, 0, 3'b100, 3'b100, 2'd0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
